// File: rtl/cache_ctrl_param.sv
// -----------------------------------------------------------------------------
// cache_ctrl_param
// Sequencing controller for a direct-mapped data cache. It sits between the
// CPU strobe interface, the tag/data array control and a fixed-latency memory.
// Supports multi-word line fills, optional write-back with dirty eviction, and
// saturating hit/miss statistics.
//
// Parameters
//   WAIT_STATES : memory latency in cycles per beat (1..255)
//   LINE_WORDS  : words per line, one beat per word (power of 2, 1..16)
//   WB_MODE     : 0 = write-through/no-allocate, 1 = write-back/write-allocate
//   CNT_W       : width of the statistics counters
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   strobe, drw         : CPU request and direction (1 = write), taken in IDLE
//   m, v, dirty         : tag match, valid and dirty bits for the current index
//   dready              : one-cycle request-complete pulse to the CPU
//   w, wsel, rsel       : data-array write enable / write source / read source
//   word_idx            : word within the line for array and memory access
//   evict               : memory address from victim tag (1) or request (0)
//   mstrobe, mrw        : memory request pulse and direction (1 = write)
//   tag_we, set_dirty   : tag-array updates
//   busy                : high in every state except IDLE
//   hit_cnt, miss_cnt   : saturating lookup statistics
// -----------------------------------------------------------------------------
module cache_ctrl_param #(
   parameter  int unsigned WAIT_STATES = 4,
   parameter  int unsigned LINE_WORDS  = 4,
   parameter  int unsigned WB_MODE     = 1,
   parameter  int unsigned CNT_W       = 16,
   localparam int unsigned IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic             drw,
   input  logic             m,
   input  logic             v,
   input  logic             dirty,
   output logic             dready,
   output logic             w,
   output logic             wsel,
   output logic             rsel,
   output logic [IDX_W-1:0] word_idx,
   output logic             evict,
   output logic             mstrobe,
   output logic             mrw,
   output logic             tag_we,
   output logic             set_dirty,
   output logic             busy,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_LOOKUP    = 4'd1;
   localparam logic [3:0] S_WB_REQ    = 4'd2;
   localparam logic [3:0] S_WB_WAIT   = 4'd3;
   localparam logic [3:0] S_FILL_REQ  = 4'd4;
   localparam logic [3:0] S_FILL_WAIT = 4'd5;
   localparam logic [3:0] S_FILL_WORD = 4'd6;
   localparam logic [3:0] S_WT_REQ    = 4'd7;
   localparam logic [3:0] S_WT_WAIT   = 4'd8;
   localparam logic [3:0] S_DONE      = 4'd9;

   localparam bit               WB        = (WB_MODE != 0);
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);
   // Wait states count down from WAIT_STATES-1 so each one lasts WAIT_STATES cycles.
   localparam logic [7:0]       WAIT_LOAD = 8'(WAIT_STATES - 1);

   logic [3:0]       state_q,    state_d;
   logic [IDX_W-1:0] beat_q,     beat_d;
   logic [7:0]       wait_q,     wait_d;
   logic             drw_q,      drw_d;
   logic [CNT_W-1:0] hit_cnt_q,  hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic lookup_hit;
   assign lookup_hit = m & v;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         wait_q     <= '0;
         drw_q      <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         wait_q     <= wait_d;
         drw_q      <= drw_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every variable gets a default first, so paths that do not assign
      // it hold the flop value instead of inferring a latch.
      state_d    = state_q;
      beat_d     = beat_q;
      wait_d     = wait_q;
      drw_d      = drw_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (strobe) begin
               drw_d   = drw;
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            // Every lookup, replays included, bumps exactly one counter.
            if (lookup_hit) begin
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else begin
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end

            if (drw_q && !WB)             state_d = S_WT_REQ;
            else if (lookup_hit)          state_d = S_IDLE;
            else if (WB && v && dirty)    state_d = S_WB_REQ;
            else                          state_d = S_FILL_REQ;
         end

         S_WB_REQ: begin
            wait_d  = WAIT_LOAD;
            state_d = S_WB_WAIT;
         end

         S_WB_WAIT: begin
            if (wait_q == '0) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = S_FILL_REQ;
               end else begin
                  beat_d  = beat_q + 1'b1;
                  state_d = S_WB_REQ;
               end
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end

         S_FILL_REQ: begin
            wait_d  = WAIT_LOAD;
            state_d = S_FILL_WAIT;
         end

         S_FILL_WAIT: begin
            if (wait_q == '0) state_d = S_FILL_WORD;
            else              wait_d  = wait_q - 1'b1;
         end

         S_FILL_WORD: begin
            // After the last word the request is replayed through LOOKUP.
            if (beat_q == LAST_BEAT) begin
               beat_d  = '0;
               state_d = S_LOOKUP;
            end else begin
               beat_d  = beat_q + 1'b1;
               state_d = S_FILL_REQ;
            end
         end

         S_WT_REQ: begin
            wait_d  = WAIT_LOAD;
            state_d = S_WT_WAIT;
         end

         S_WT_WAIT: begin
            if (wait_q == '0) state_d = S_DONE;
            else              wait_d  = wait_q - 1'b1;
         end

         S_DONE:  state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // Output decode. Outputs are forced low while reset is asserted so an
   // aborted operation never emits tag_we or dready in the reset cycle.
   always_comb begin
      dready    = 1'b0;
      w         = 1'b0;
      wsel      = 1'b0;
      rsel      = 1'b0;
      evict     = 1'b0;
      mstrobe   = 1'b0;
      mrw       = 1'b0;
      tag_we    = 1'b0;
      set_dirty = 1'b0;
      word_idx  = beat_q;
      busy      = (state_q != S_IDLE);
      hit_cnt   = hit_cnt_q;
      miss_cnt  = miss_cnt_q;

      case (state_q)
         S_LOOKUP: begin
            if (lookup_hit && drw_q) begin
               w    = 1'b1;
               wsel = 1'b0;
               if (WB) begin
                  set_dirty = 1'b1;
                  dready    = 1'b1;
               end
            end else if (lookup_hit) begin
               dready = 1'b1;
               rsel   = 1'b0;
            end
         end
         S_WB_REQ: begin
            mstrobe = 1'b1;
            mrw     = 1'b1;
            evict   = 1'b1;
         end
         S_WB_WAIT: begin
            mrw   = 1'b1;
            evict = 1'b1;
         end
         S_FILL_REQ:  mstrobe = 1'b1;
         S_FILL_WORD: begin
            w      = 1'b1;
            wsel   = 1'b1;
            tag_we = (beat_q == LAST_BEAT);
         end
         S_WT_REQ: begin
            mstrobe = 1'b1;
            mrw     = 1'b1;
         end
         S_WT_WAIT: mrw    = 1'b1;
         S_DONE:    dready = 1'b1;
         default: ;
      endcase

      if (reset) begin
         dready    = 1'b0;
         w         = 1'b0;
         wsel      = 1'b0;
         rsel      = 1'b0;
         evict     = 1'b0;
         mstrobe   = 1'b0;
         mrw       = 1'b0;
         tag_we    = 1'b0;
         set_dirty = 1'b0;
         word_idx  = '0;
         busy      = 1'b0;
         hit_cnt   = '0;
         miss_cnt  = '0;
      end
   end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_param
// Two controller instances: dut0 is write-back (4 wait states, 4-word lines,
// 16-bit counters), dut1 is write-through (2 wait states, 4-word lines, 2-bit
// counters). A driver issues directed and random requests, plays the role of
// the tag array (match/valid after tag_we) and pushes the expected outcome of
// each request into a per-instance queue. A monitor per instance observes the
// DUT, tallies events per request and compares when dready appears.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_param;

   localparam int A_WS = 4, A_LW = 4, A_WB = 1, A_CW = 16;
   localparam int B_WS = 2, B_LW = 4, B_WB = 0, B_CW = 2;
   localparam int TIMEOUT = 300;

   typedef struct {
      int lat;     // cycle of dready, strobe cycle = 0
      int n_rd;    // memory read requests
      int n_wr;    // memory write requests
      int n_w;     // data-array writes
      int n_fill;  // data-array writes from memory
      int n_tag;   // tag writes
      int n_sd;    // set_dirty pulses
      int n_ev;    // cycles with evict high
      int hits;    // counter values after the request
      int misses;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst, strobe, drw, m, v, dirty;
   wire  [1:0] dready, w, wsel, rsel, evict, mstrobe, mrw, tag_we, set_dirty, busy;
   wire  [1:0] word_idx [2];
   wire [15:0] hit_cnt  [2];
   wire [15:0] miss_cnt [2];

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   tot_hits   [2];
   int   tot_misses [2];

   task automatic check(input int i, input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %0d, expected %0d (t=%0t)", i, name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] outs(input int i);
      return {dready[i], w[i], wsel[i], rsel[i], evict[i], mstrobe[i],
              mrw[i], tag_we[i], set_dirty[i], busy[i], word_idx[i]};
   endfunction

   // Reference outcome of one request, from the controller's policy rules.
   function automatic exp_t model(input int i, input bit rw, input bit mm,
                                  input bit vv, input bit dd);
      exp_t e;
      int   ws, lw;
      bit   wb, hit, wt, fill, ev;
      ws   = (i == 0) ? A_WS : B_WS;
      lw   = (i == 0) ? A_LW : B_LW;
      wb   = (i == 0) ? (A_WB != 0) : (B_WB != 0);
      hit  = mm && vv;
      wt   = !wb && rw;
      fill = !wt && !hit;
      ev   = fill && wb && vv && dd;
      if (wt)       e.lat = ws + 3;
      else if (hit) e.lat = 1;
      else          e.lat = 2 + lw * (ws + 2) + (ev ? lw * (ws + 1) : 0);
      e.n_rd   = fill ? lw : 0;
      e.n_wr   = ev ? lw : (wt ? 1 : 0);
      e.n_fill = fill ? lw : 0;
      e.n_w    = e.n_fill + ((rw && (hit || fill)) ? 1 : 0);
      e.n_tag  = fill ? 1 : 0;
      e.n_sd   = (wb && rw) ? 1 : 0;
      e.n_ev   = ev ? lw * (ws + 1) : 0;
      // Deltas: a fill ends in a replay lookup that hits.
      e.hits   = (hit || fill) ? 1 : 0;
      e.misses = hit ? 0 : 1;
      return e;
   endfunction

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         localparam int WS = (g == 0) ? A_WS : B_WS;
         localparam int LW = (g == 0) ? A_LW : B_LW;
         localparam int WB = (g == 0) ? A_WB : B_WB;
         localparam int CW = (g == 0) ? A_CW : B_CW;

         wire [CW-1:0] hc, mc;

         cache_ctrl_param #(
            .WAIT_STATES(WS),
            .LINE_WORDS (LW),
            .WB_MODE    (WB),
            .CNT_W      (CW)
         ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .strobe   (strobe[g]),
            .drw      (drw[g]),
            .m        (m[g]),
            .v        (v[g]),
            .dirty    (dirty[g]),
            .dready   (dready[g]),
            .w        (w[g]),
            .wsel     (wsel[g]),
            .rsel     (rsel[g]),
            .word_idx (word_idx[g]),
            .evict    (evict[g]),
            .mstrobe  (mstrobe[g]),
            .mrw      (mrw[g]),
            .tag_we   (tag_we[g]),
            .set_dirty(set_dirty[g]),
            .busy     (busy[g]),
            .hit_cnt  (hc),
            .miss_cnt (mc)
         );

         assign hit_cnt[g]  = 16'(hc);
         assign miss_cnt[g] = 16'(mc);

         // Monitor: samples on the falling edge, tallies one request at a time.
         initial begin
            int   cyc, rd_k, wr_k, fw_k, n_rd, n_wr, n_w, n_fill, n_tag, n_sd, n_ev;
            int   idx_err, idle_err, rsel_n;
            bit   in_flight, cnt_pend;
            exp_t e, pend;
            in_flight = 1'b0;
            cnt_pend  = 1'b0;
            idle_err  = 0;
            forever begin
               @(negedge clk);
               if (cnt_pend) begin
                  cnt_pend = 1'b0;
                  check(g, "hit_cnt", int'(hit_cnt[g]), pend.hits);
                  check(g, "miss_cnt", int'(miss_cnt[g]), pend.misses);
               end
               if (rst[g]) begin
                  in_flight = 1'b0;
                  continue;
               end
               if (!in_flight) begin
                  if (busy[g]) begin
                     in_flight = 1'b1;
                     cyc = 1; rd_k = 0; wr_k = 0; fw_k = 0;
                     n_rd = 0; n_wr = 0; n_w = 0; n_fill = 0; n_tag = 0;
                     n_sd = 0; n_ev = 0; idx_err = 0; rsel_n = 0;
                  end else if (outs(g) != '0) begin
                     idle_err++;
                  end
               end else begin
                  cyc++;
               end
               if (in_flight) begin
                  if (mstrobe[g] && !mrw[g]) begin
                     if (int'(word_idx[g]) != rd_k % LW) idx_err++;
                     rd_k++; n_rd++;
                  end
                  if (mstrobe[g] && mrw[g]) begin
                     if (int'(word_idx[g]) != wr_k % LW) idx_err++;
                     wr_k++; n_wr++;
                  end
                  if (w[g]) n_w++;
                  if (w[g] && wsel[g]) begin
                     if (int'(word_idx[g]) != fw_k % LW) idx_err++;
                     fw_k++; n_fill++;
                  end
                  if (tag_we[g])    n_tag++;
                  if (set_dirty[g]) n_sd++;
                  if (evict[g])     n_ev++;
                  if (rsel[g])      rsel_n++;
                  if (dready[g]) begin
                     in_flight = 1'b0;
                     if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                        check(g, "unexpected_dready", 1, 0);
                     end else begin
                        if (g == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check(g, "latency",   cyc,      e.lat);
                        check(g, "mem_reads", n_rd,     e.n_rd);
                        check(g, "mem_writes", n_wr,    e.n_wr);
                        check(g, "array_w",   n_w,      e.n_w);
                        check(g, "fill_w",    n_fill,   e.n_fill);
                        check(g, "tag_we",    n_tag,    e.n_tag);
                        check(g, "set_dirty", n_sd,     e.n_sd);
                        check(g, "evict_cyc", n_ev,     e.n_ev);
                        check(g, "word_idx",  idx_err,  0);
                        check(g, "rsel",      rsel_n,   0);
                        check(g, "idle_quiet", idle_err, 0);
                        idle_err = 0;
                        pend     = e;
                        cnt_pend = 1'b1;
                     end
                  end
               end
            end
         end
      end
   endgenerate

   task automatic recover(input int i);
      rst[i]    = 1'b1;
      strobe[i] = 1'b0;
      @(negedge clk); #1;
      rst[i] = 1'b0;
      if (i == 0) q0.delete();
      else        q1.delete();
      tot_hits[i]   = 0;
      tot_misses[i] = 0;
   endtask

   // One request. hold keeps strobe high until dready; abort resets the DUT
   // in FILL_WAIT of beat 2 and checks the post-reset state.
   task automatic do_req(input int i, input bit rw, input bit mm, input bit vv,
                         input bit dd, input bit hold, input bit abort);
      exp_t e;
      int   cap, fills;
      bit   done, arm;
      cap = (1 << ((i == 0) ? A_CW : B_CW)) - 1;
      @(negedge clk); #1;
      if (!abort) begin
         e = model(i, rw, mm, vv, dd);
         tot_hits[i]   = (tot_hits[i] + e.hits > cap) ? cap : tot_hits[i] + e.hits;
         tot_misses[i] = (tot_misses[i] + e.misses > cap) ? cap : tot_misses[i] + e.misses;
         e.hits   = tot_hits[i];
         e.misses = tot_misses[i];
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      strobe[i] = 1'b1;
      drw[i]    = rw;
      m[i]      = mm;
      v[i]      = vv;
      dirty[i]  = dd;
      done  = 1'b0;
      arm   = 1'b0;
      fills = 0;
      for (int c = 0; c < TIMEOUT && !done; c++) begin
         @(negedge clk); #1;
         if (!hold) strobe[i] = 1'b0;
         if (arm) begin
            rst[i] = 1'b1;
            #1;
            check(i, "outs_in_reset", int'(outs(i)), 0);
            @(negedge clk); #1;
            rst[i] = 1'b0;
            #1;
            check(i, "outs_after_abort", int'(outs(i)), 0);
            check(i, "hit_cnt_after_abort", int'(hit_cnt[i]), 0);
            check(i, "miss_cnt_after_abort", int'(miss_cnt[i]), 0);
            tot_hits[i]   = 0;
            tot_misses[i] = 0;
            done = 1'b1;
         end else begin
            if (tag_we[i]) begin
               m[i]     = 1'b1;
               v[i]     = 1'b1;
               dirty[i] = 1'b0;
            end
            if (set_dirty[i]) dirty[i] = 1'b1;
            if (mstrobe[i] && !mrw[i]) begin
               fills++;
               if (abort && fills == 3) arm = 1'b1;
            end
            if (dready[i]) begin
               strobe[i] = 1'b0;
               done      = 1'b1;
            end
         end
      end
      check(i, "completes", int'(done), 1);
      if (!done) recover(i);
   endtask

   task automatic rand_req(input int i);
      do_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
   endtask

   initial begin
      rst    = '1;
      strobe = '0;
      drw    = '0;
      m      = '0;
      v      = '0;
      dirty  = '0;
      tot_hits   = '{0, 0};
      tot_misses = '{0, 0};
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) check(i, "outs_during_reset", int'(outs(i)), 0);
      rst = '0;
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check(i, "outs_after_reset", int'(outs(i)), 0);
         check(i, "hit_cnt_reset",  int'(hit_cnt[i]), 0);
         check(i, "miss_cnt_reset", int'(miss_cnt[i]), 0);
      end

      // Write-back instance.
      do_req(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // read hit
      do_req(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // clean read miss
      do_req(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // dirty write miss
      do_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // write hit
      do_req(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // read miss, reset mid-fill
      do_req(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // restart from word 0
      do_req(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // dirty miss, strobe held
      do_req(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // match but invalid
      repeat (20) rand_req(0);

      // Write-through instance.
      do_req(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // write hit
      do_req(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // write miss
      repeat (5) do_req(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // saturate hits
      do_req(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // read miss, dirty ignored
      repeat (20) rand_req(1);

      repeat (4) @(negedge clk);
      check(0, "scoreboard_empty", q0.size(), 0);
      check(1, "scoreboard_empty", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
